// File: rtl/memory.sv
// rv32 memory-access stage: services loads and stores on the data bus,
// aligns and extends load data, and hands a wb_t beat to writeback.

package core;
   typedef enum logic [2:0] {
      NONE   = 3'd0,
      JUMP   = 3'd1,
      BRANCH = 3'd2,
      LOAD   = 3'd3,
      STORE  = 3'd4,
      REG    = 3'd5
   } op_t;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd3,
      LHU = 3'd4,
      SB  = 3'd5,
      SH  = 3'd6,
      SW  = 3'd7
   } mem_t;

   typedef struct packed {
      op_t  op;
      mem_t mem;
   } mm_ctrl_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rs2;
   } mm_data_t;

   typedef struct packed {
      mm_ctrl_t ctrl;
      mm_data_t data;
   } mm_t;

   typedef struct packed {
      op_t op;
   } wb_ctrl_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] value;
   } wb_data_t;

   typedef struct packed {
      wb_ctrl_t ctrl;
      wb_data_t data;
   } wb_t;
endpackage

module memory
   import core::*;
(
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        source_tvalid,
   output logic                        source_tready,
   input  logic [$bits(core::mm_t)-1:0] source_tdata,
   output logic                        sink_tvalid,
   input  logic                        sink_tready,
   output logic [$bits(core::wb_t)-1:0] sink_tdata,
   output logic                        dmem_req,
   output logic                        dmem_we,
   output logic [3:0]                  dmem_be,
   output logic [31:0]                 dmem_addr,
   output logic [31:0]                 dmem_wdata,
   input  logic                        dmem_gnt,
   input  logic                        dmem_rvalid,
   input  logic [31:0]                 dmem_rdata,
   output logic [31:0]                 bypass,
   output logic                        misaligned
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RESP  = 2'd2,
      VALID = 2'd3
   } state_t;

   function automatic logic is_misaligned(input mem_t m, input logic [1:0] o);
      logic r;
      case (m)
         LH, LHU, SH: r = o[0];
         LW, SW:      r = (o != 2'b00);
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] store_be(input mem_t m, input logic [1:0] o);
      logic [3:0] r;
      case (m)
         SB:      r = 4'b0001 << o;
         SH:      r = 4'b0011 << o;
         default: r = 4'b1111;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_wdata(input mem_t m, input logic [31:0] rs2);
      logic [31:0] r;
      case (m)
         SB:      r = {4{rs2[7:0]}};
         SH:      r = {2{rs2[15:0]}};
         default: r = rs2;
      endcase
      return r;
   endfunction

   // Shift the addressed lane down to bit 0, then extend to 32 bits.
   function automatic logic [31:0] load_value(input mem_t m, input logic [1:0] o,
                                              input logic [31:0] rdata);
      logic [31:0] s;
      logic [31:0] r;
      s = rdata >> {o, 3'b000};
      case (m)
         LB:      r = {{24{s[7]}}, s[7:0]};
         LBU:     r = {24'h000000, s[7:0]};
         LH:      r = {{16{s[15]}}, s[15:0]};
         LHU:     r = {16'h0000, s[15:0]};
         default: r = rdata;
      endcase
      return r;
   endfunction

   state_t      state_r;
   op_t         op_r;
   mem_t        mem_r;
   logic [4:0]  rd_r;
   logic [31:0] alu_r;
   logic        req_r;
   logic        we_r;
   logic [3:0]  be_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   op_t         wb_op_r;
   logic [4:0]  wb_rd_r;
   logic [31:0] wb_value_r;
   logic        mis_r;

   mm_t         beat_s;
   wb_t         wb_s;
   logic        ready_s;
   logic        accept_s;
   logic        mem_op_s;
   logic        is_store_s;
   logic        mis_s;

   assign beat_s     = mm_t'(source_tdata);
   assign ready_s    = ~areset & ((state_r == IDLE) | ((state_r == VALID) & sink_tready));
   assign accept_s   = source_tvalid & ready_s;
   assign is_store_s = (beat_s.ctrl.op == STORE);
   assign mem_op_s   = (beat_s.ctrl.op == LOAD) | is_store_s;
   assign mis_s      = mem_op_s & is_misaligned(beat_s.ctrl.mem, beat_s.data.alu[1:0]);

   // Pack the writeback registers into the sink beat.
   always_comb begin
      wb_s            = '0;
      wb_s.ctrl.op    = wb_op_r;
      wb_s.data.rd    = wb_rd_r;
      wb_s.data.value = wb_value_r;
   end

   // Stage FSM: dispatch, bus request, response wait, and result hold.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r    <= IDLE;
         op_r       <= NONE;
         mem_r      <= LB;
         rd_r       <= 5'd0;
         alu_r      <= 32'd0;
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         be_r       <= 4'b0000;
         addr_r     <= 32'd0;
         wdata_r    <= 32'd0;
         wb_op_r    <= NONE;
         wb_rd_r    <= 5'd0;
         wb_value_r <= 32'd0;
         mis_r      <= 1'b0;
      end else begin
         mis_r <= 1'b0;
         case (state_r)
            IDLE, VALID: begin
               if (accept_s) begin
                  op_r  <= beat_s.ctrl.op;
                  mem_r <= beat_s.ctrl.mem;
                  rd_r  <= beat_s.data.rd;
                  alu_r <= beat_s.data.alu;
                  if (mis_s) begin
                     // Faulting access: emit a harmless bubble, never touch the bus.
                     state_r    <= VALID;
                     wb_op_r    <= NONE;
                     wb_rd_r    <= 5'd0;
                     wb_value_r <= beat_s.data.alu;
                     mis_r      <= 1'b1;
                  end else if (mem_op_s) begin
                     state_r <= REQ;
                     req_r   <= 1'b1;
                     we_r    <= is_store_s;
                     addr_r  <= {beat_s.data.alu[31:2], 2'b00};
                     if (is_store_s) begin
                        be_r    <= store_be(beat_s.ctrl.mem, beat_s.data.alu[1:0]);
                        wdata_r <= store_wdata(beat_s.ctrl.mem, beat_s.data.rs2);
                     end else begin
                        be_r    <= 4'b1111;
                        wdata_r <= 32'd0;
                     end
                  end else begin
                     state_r    <= VALID;
                     wb_op_r    <= beat_s.ctrl.op;
                     wb_rd_r    <= beat_s.data.rd;
                     wb_value_r <= beat_s.data.alu;
                  end
               end else if ((state_r == VALID) && sink_tready) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  req_r <= 1'b0;
                  we_r  <= 1'b0;
                  be_r  <= 4'b0000;
                  if (op_r == STORE) begin
                     state_r    <= VALID;
                     wb_op_r    <= op_r;
                     wb_rd_r    <= rd_r;
                     wb_value_r <= alu_r;
                  end else begin
                     state_r <= RESP;
                  end
               end else begin
                  state_r <= REQ;
               end
            end
            RESP: begin
               if (dmem_rvalid) begin
                  state_r    <= VALID;
                  wb_op_r    <= op_r;
                  wb_rd_r    <= rd_r;
                  wb_value_r <= load_value(mem_r, alu_r[1:0], dmem_rdata);
               end else begin
                  state_r <= RESP;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign source_tready = ready_s;
   assign sink_tvalid   = (state_r == VALID);
   assign sink_tdata    = wb_s;
   assign dmem_req      = req_r;
   assign dmem_we       = we_r;
   assign dmem_be       = be_r;
   assign dmem_addr     = addr_r;
   assign dmem_wdata    = wdata_r;
   assign bypass        = wb_value_r;
   assign misaligned    = mis_r;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the memory stage: directed beats, a bus responder
// that checks requests, and a sink monitor that checks writeback beats.

module tb_memory;
   import core::*;

   logic                    aclk = 1'b0;
   logic                    areset = 1'b1;
   logic                    source_tvalid = 1'b0;
   logic                    source_tready;
   logic [$bits(mm_t)-1:0]  source_tdata = '0;
   logic                    sink_tvalid;
   logic                    sink_tready = 1'b1;
   logic [$bits(wb_t)-1:0]  sink_tdata;
   logic                    dmem_req;
   logic                    dmem_we;
   logic [3:0]              dmem_be;
   logic [31:0]             dmem_addr;
   logic [31:0]             dmem_wdata;
   logic                    dmem_gnt = 1'b0;
   logic                    dmem_rvalid = 1'b0;
   logic [31:0]             dmem_rdata = 32'd0;
   logic [31:0]             bypass;
   logic                    misaligned;

   memory dut (
      .aclk(aclk), .areset(areset),
      .source_tvalid(source_tvalid), .source_tready(source_tready), .source_tdata(source_tdata),
      .sink_tvalid(sink_tvalid), .sink_tready(sink_tready), .sink_tdata(sink_tdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .bypass(bypass), .misaligned(misaligned)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      op_t         op;
      logic [4:0]  rd;
      logic [31:0] value;
      bit          chk_val;
   } exp_wb_t;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_bus_t;

   exp_wb_t  wb_q[$];
   exp_bus_t bus_q[$];
   wb_t      wb;
   int       total = 0;
   int       bad = 0;
   int       beats_seen = 0;
   int       beats_pushed = 0;
   int       grants = 0;
   int       mis_seen = 0;
   int       gnt_delay = 0;
   int       rv_delay = 0;
   logic [31:0] rdata_val = 32'd0;

   assign wb = wb_t'(sink_tdata);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_wb(input op_t op, input logic [4:0] rd, input logic [31:0] v, input bit cv);
      exp_wb_t e;
      e.op = op; e.rd = rd; e.value = v; e.chk_val = cv;
      wb_q.push_back(e);
      beats_pushed++;
   endtask

   task automatic push_bus(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      exp_bus_t e;
      e.we = we; e.be = be; e.addr = a; e.wdata = d;
      bus_q.push_back(e);
   endtask

   // Sink monitor: pops the scoreboard on every writeback handshake.
   initial begin
      exp_wb_t e;
      forever begin
         @(negedge aclk);
         if (!areset && sink_tvalid && sink_tready) begin
            beats_seen++;
            if (wb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_beat: got op=%0d rd=%0d value=0x%08h expected none",
                        wb.ctrl.op, wb.data.rd, wb.data.value);
            end else begin
               e = wb_q.pop_front();
               chk("wb_op", wb.ctrl.op, e.op);
               chk("wb_rd", wb.data.rd, e.rd);
               if (e.chk_val) begin
                  chk("wb_value", wb.data.value, e.value);
                  chk("bypass", bypass, e.value);
               end
            end
         end
         if (misaligned) begin
            mis_seen++;
            chk("mis_with_valid", sink_tvalid, 1);
         end
      end
   end

   // Bus responder: checks each request against the queue and for stability, then grants/returns data.
   initial begin
      exp_bus_t e;
      exp_bus_t snap;
      bit req_active = 0;
      bit resp_pending = 0;
      int g_cnt = 0;
      int rv_cnt = 0;
      forever begin
         @(negedge aclk);
         dmem_gnt = 1'b0;
         dmem_rvalid = 1'b0;
         if (areset) begin
            req_active = 0;
            g_cnt = 0;
         end
         if (resp_pending) begin
            if (rv_cnt == rv_delay) begin
               dmem_rvalid = 1'b1;
               dmem_rdata = rdata_val;
               resp_pending = 0;
            end else begin
               rv_cnt++;
            end
         end
         if (!areset && dmem_req) begin
            if (!req_active) begin
               req_active = 1;
               snap.we = dmem_we; snap.be = dmem_be; snap.addr = dmem_addr; snap.wdata = dmem_wdata;
               if (bus_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_req: got addr=0x%08h we=%0b expected none", dmem_addr, dmem_we);
               end else begin
                  e = bus_q.pop_front();
                  chk("req_we", dmem_we, e.we);
                  chk("req_be", dmem_be, e.be);
                  chk("req_addr", dmem_addr, e.addr);
                  chk("req_wdata", dmem_wdata, e.wdata);
               end
            end else begin
               chk("req_stable_addr", dmem_addr, snap.addr);
               chk("req_stable_be", dmem_be, snap.be);
               chk("req_stable_we", dmem_we, snap.we);
               chk("req_stable_wdata", dmem_wdata, snap.wdata);
            end
            if (g_cnt == gnt_delay) begin
               dmem_gnt = 1'b1;
               g_cnt = 0;
               req_active = 0;
               grants++;
               if (!dmem_we) begin
                  resp_pending = 1;
                  rv_cnt = 0;
               end
            end else begin
               g_cnt++;
            end
         end
      end
   end

   task automatic send(input op_t op, input mem_t m, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2, output int waited);
      mm_t b;
      b.ctrl.op = op; b.ctrl.mem = m; b.data.rd = rd; b.data.alu = alu; b.data.rs2 = rs2;
      source_tdata = b;
      source_tvalid = 1'b1;
      waited = 0;
      @(negedge aclk);
      while (!source_tready && waited < 200) begin
         waited++;
         @(negedge aclk);
      end
      if (waited >= 200) begin
         total++; bad++;
         $display("FAIL accept_timeout: got no source_tready expected accept");
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic idle();
      source_tvalid = 1'b0;
   endtask

   task automatic wait_sink(input string name);
      int n = 0;
      @(negedge aclk);
      while (!sink_tvalid && n < 100) begin
         n++;
         @(negedge aclk);
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL %s_timeout: got no sink_tvalid expected beat", name);
      end
      repeat (2) @(posedge aclk);
      #1;
   endtask

   initial begin
      #400000;
      total++; bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int w;
      int g0;
      logic [31:0] held;

      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("rst_source_tready", source_tready, 0);
      chk("rst_sink_tvalid", sink_tvalid, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_dmem_be", dmem_be, 0);
      chk("rst_misaligned", misaligned, 0);
      chk("rst_op", wb.ctrl.op, NONE);
      chk("rst_rd", wb.data.rd, 0);
      chk("rst_value", wb.data.value, 0);
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      chk("idle_source_tready", source_tready, 1);
      @(posedge aclk); #1;

      // REG beat: result one cycle after acceptance.
      push_wb(REG, 5'd5, 32'h0000_1234, 1);
      send(REG, LB, 5'd5, 32'h0000_1234, 32'd0, w);
      idle();
      @(negedge aclk);
      chk("reg_latency", sink_tvalid, 1);
      chk("reg_tready", source_tready, 1);
      @(posedge aclk); #1;

      // Back-to-back non-memory beats.
      for (int i = 1; i <= 3; i++) begin
         push_wb(JUMP, 5'(i), 32'h100 * i, 1);
         send(JUMP, LB, 5'(i), 32'h100 * i, 32'd0, w);
         if (i > 1) chk("b2b_no_stall", w, 0);
      end
      idle();
      wait_sink("b2b");

      // Backpressure: result held until sink_tready.
      sink_tready = 1'b0;
      push_wb(BRANCH, 5'd9, 32'h0000_BEEF, 1);
      send(BRANCH, LB, 5'd9, 32'h0000_BEEF, 32'd0, w);
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("bp_valid", sink_tvalid, 1);
         chk("bp_hold", wb.data.value, 32'h0000_BEEF);
         chk("bp_tready", source_tready, 0);
      end
      @(posedge aclk); #1;
      sink_tready = 1'b1;
      wait_sink("bp");

      // SB at offset 3, immediate grant.
      gnt_delay = 0;
      push_bus(1'b1, 4'b1000, 32'h0000_1000, 32'hDDDD_DDDD);
      push_wb(STORE, 5'd7, 32'h0000_1003, 1);
      send(STORE, SB, 5'd7, 32'h0000_1003, 32'hAABB_CCDD, w);
      idle();
      @(negedge aclk);
      chk("sb_req_n1", dmem_req, 1);
      chk("sb_valid_n1", sink_tvalid, 0);
      @(negedge aclk);
      chk("sb_valid_n2", sink_tvalid, 1);
      @(posedge aclk); #1;

      // SH at offset 2.
      push_bus(1'b1, 4'b1100, 32'h0000_1000, 32'hABCD_ABCD);
      push_wb(STORE, 5'd8, 32'h0000_1002, 1);
      send(STORE, SH, 5'd8, 32'h0000_1002, 32'h1234_ABCD, w);
      idle();
      wait_sink("sh");

      // LB at 0x2001: sign extension, three-cycle latency.
      rv_delay = 0;
      rdata_val = 32'h0000_8000;
      push_bus(1'b0, 4'b1111, 32'h0000_2000, 32'd0);
      push_wb(LOAD, 5'd3, 32'hFFFF_FF80, 1);
      send(LOAD, LB, 5'd3, 32'h0000_2001, 32'd0, w);
      idle();
      @(negedge aclk);
      chk("lb_req_n1", dmem_req, 1);
      chk("lb_valid_n1", sink_tvalid, 0);
      @(negedge aclk);
      chk("lb_valid_n2", sink_tvalid, 0);
      @(negedge aclk);
      chk("lb_valid_n3", sink_tvalid, 1);
      @(posedge aclk); #1;

      push_bus(1'b0, 4'b1111, 32'h0000_2000, 32'd0);
      push_wb(LOAD, 5'd3, 32'h0000_0080, 1);
      send(LOAD, LBU, 5'd3, 32'h0000_2001, 32'd0, w);
      idle();
      wait_sink("lbu");

      rdata_val = 32'h8001_0000;
      push_bus(1'b0, 4'b1111, 32'h0000_2000, 32'd0);
      push_wb(LOAD, 5'd4, 32'hFFFF_8001, 1);
      send(LOAD, LH, 5'd4, 32'h0000_2002, 32'd0, w);
      idle();
      wait_sink("lh");

      push_bus(1'b0, 4'b1111, 32'h0000_2000, 32'd0);
      push_wb(LOAD, 5'd4, 32'h0000_8001, 1);
      send(LOAD, LHU, 5'd4, 32'h0000_2002, 32'd0, w);
      idle();
      wait_sink("lhu");

      // LW with slow grant and slow data.
      gnt_delay = 3;
      rv_delay = 2;
      rdata_val = 32'hDEAD_BEEF;
      push_bus(1'b0, 4'b1111, 32'h0000_4000, 32'd0);
      push_wb(LOAD, 5'd10, 32'hDEAD_BEEF, 1);
      send(LOAD, LW, 5'd10, 32'h0000_4000, 32'd0, w);
      idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         chk("lw_wait_tready", source_tready, 0);
      end
      wait_sink("lw");
      gnt_delay = 0;
      rv_delay = 0;

      // Misaligned SW: bubble, pulse, no bus traffic.
      g0 = grants;
      push_wb(NONE, 5'd0, 32'd0, 0);
      send(STORE, SW, 5'd9, 32'h0000_3002, 32'h0000_0055, w);
      idle();
      @(negedge aclk);
      chk("mis_valid", sink_tvalid, 1);
      chk("mis_pulse", misaligned, 1);
      chk("mis_no_req", dmem_req, 0);
      @(negedge aclk);
      chk("mis_pulse_end", misaligned, 0);
      chk("mis_no_req2", dmem_req, 0);
      chk("mis_no_grant", grants, g0);
      @(posedge aclk); #1;

      // Reset while a load waits for data; the late rvalid must be ignored.
      rv_delay = 3;
      rdata_val = 32'h1111_1111;
      push_bus(1'b0, 4'b1111, 32'h0000_5000, 32'd0);
      send(LOAD, LW, 5'd4, 32'h0000_5000, 32'd0, w);
      idle();
      @(negedge aclk);
      @(posedge aclk); #1;
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      chk("rr_req", dmem_req, 0);
      chk("rr_valid", sink_tvalid, 0);
      chk("rr_tready", source_tready, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("rr_no_beat", sink_tvalid, 0);
      end
      @(posedge aclk); #1;
      rv_delay = 0;
      push_wb(REG, 5'd6, 32'h0000_CAFE, 1);
      send(REG, LB, 5'd6, 32'h0000_CAFE, 32'd0, w);
      idle();
      @(negedge aclk);
      chk("rr_next_valid", sink_tvalid, 1);
      repeat (3) @(posedge aclk);
      #1;

      held = 32'(wb_q.size());
      chk("sb_empty", held, 0);
      chk("bus_q_empty", bus_q.size(), 0);
      chk("beat_count", beats_seen, beats_pushed);
      chk("mis_count", mis_seen, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory.md
# memory

Memory-access stage of the rv32 pipeline. It consumes the `core::mm_t` stream that execute produces and services loads and stores on the data-memory bus. Loads get byte-lane extraction and sign or zero extension. It forwards a `core::wb_t` result to writeback and publishes a bypass value for hazard forwarding.

## Interface
- No parameters.
- `aclk` in 1: clock; all state changes on the rising edge.
- `areset` in 1: synchronous, active-high reset.
- `source_tvalid` in 1: `mm_t` beat valid.
- `source_tready` out 1: stage can accept a beat.
- `source_tdata` in `$bits(mm_t)`:
  - `ctrl.op` is `core::NONE`/`JUMP`/`BRANCH`/`LOAD`/`STORE`/`REG`.
  - `ctrl.mem` is one of LB, LH, LW, LBU, LHU, SB, SH, SW.
  - `data.rd`, `data.alu`, `data.rs2`.
- `sink_tvalid` out 1: `wb_t` beat valid.
- `sink_tready` in 1: writeback accepts.
- `sink_tdata` out `$bits(wb_t)`: `ctrl.op`, `data.rd`, `data.value`.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = store.
- `dmem_be` out 4: byte enables.
- `dmem_addr` out 32: word-aligned address.
- `dmem_wdata` out 32: store data.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read data.
- `bypass` out 32: `sink_tdata.data.value`.
- `misaligned` out 1: one-cycle pulse on a misaligned load or store.

## Operation
- States: IDLE, REQ, RESP, VALID. Reset goes to IDLE.
- `source_tready` = (IDLE) | (VALID & `sink_tready`). `sink_tvalid` = VALID.
- A beat is accepted when `source_tvalid & source_tready`. It is captured into internal registers.
- Accepted beat, per op:
  - Op not LOAD/STORE: go to VALID. `value` = `alu`; `op`/`rd` copied.
  - LOAD or STORE, aligned: go to REQ.
  - Misaligned (halfword with `alu[0]`=1, word with `alu[1:0]`≠0): go to VALID with `op`=NONE and `rd`=0. Pulse `misaligned`. No bus request is issued.
- REQ:
  - `dmem_req`=1.
  - `dmem_addr` = {`alu[31:2]`,2'b00}.
  - `dmem_we` = (op==STORE).
  - On `dmem_gnt`: a store goes to VALID with `value`=`alu`; a load goes to RESP.
  - Request fields are held stable until gnt.
- Store lanes, with `o` = `alu[1:0]`:
  - SB: `be`=4'b0001<<`o`, `wdata`={4{`rs2[7:0]`}}.
  - SH: `be`=4'b0011<<`o`, `wdata`={2{`rs2[15:0]`}}.
  - SW: `be`=4'b1111, `wdata`=`rs2`.
- For a load, `be`=4'b1111 and `wdata`=0.
- RESP: on `dmem_rvalid`, `s` = `rdata` >> (8·`alu[1:0]`).
  - LB sign-extends `s[7:0]`; LBU zero-extends it.
  - LH sign-extends `s[15:0]`; LHU zero-extends it.
  - LW uses `rdata`.
  - Result is written to `value`; go to VALID.
- VALID: hold `sink_tdata` stable until `sink_tready`. On the handshake:
  - If a new beat is accepted the same cycle, dispatch it as from IDLE.
  - Otherwise go to IDLE.
- `dmem_rvalid` outside RESP is ignored.

## Timing
- Reset values:
  - `source_tready`=0 during reset, 1 in IDLE afterwards.
  - `sink_tvalid`=0, `dmem_req`=0, `dmem_we`=0, `dmem_be`=0, `misaligned`=0.
  - `sink_tdata` op=NONE, rd=0, value=0.
- Non-memory op: accepted at cycle N, `sink_tvalid` at N+1.
- Back-to-back non-memory beats with `sink_tready`=1 sustain one beat per cycle.
- Store: accepted at N, `dmem_req` at N+1. If granted at N+1, `sink_tvalid` at N+2.
- Load:
  - Accepted at N, req at N+1, gnt at N+1, earliest `rvalid` at N+2.
  - `sink_tvalid` at N+3.
  - A load-to-use dependency therefore stalls at least 2 cycles.
- REQ and RESP hold indefinitely without gnt or rvalid. `source_tready`=0 throughout.
- `misaligned` is asserted the cycle after acceptance, together with `sink_tvalid`.
- `areset` mid-transaction:
  - Next edge returns to IDLE and drops `dmem_req`.
  - The in-flight beat is discarded.
  - A later `rvalid` is ignored.
- `bypass` is meaningful only while `sink_tvalid`=1.

## Test plan
- Reset, then REG beat with alu=0x1234, rd=5 -> `sink_tvalid` next cycle, value=0x1234, rd=5. `source_tready` stays 1 with `sink_tready`=1.
- SB at alu=0x1003, rs2=0xAABBCCDD, gnt immediate -> be=4'b1000, addr=0x1000, wdata=0xDDDDDDDD, `sink_tvalid` 2 cycles after accept.
- LB at 0x2001, rdata=0x0000_8000 -> value=0xFFFFFF80. Same with LBU -> 0x00000080. LH at 0x2002, rdata=0x8001_0000 -> 0xFFFF8001.
- LW with gnt delayed 3 cycles and rvalid delayed 2 more -> req and addr stable during the wait, `source_tready`=0, exactly one result beat.
- SW at 0x3002 -> no `dmem_req`, `misaligned` pulses once, `sink` beat op=NONE, rd=0.
- Load in RESP, assert `areset` for 1 cycle, then `rvalid` -> state IDLE, no `sink_tvalid`, next beat accepted normally.
